branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/branch_resolve.sv | 102 ++++++++++
 tb/tb_branch_resolve.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolver.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_JMP  = 3'd5
    } br_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Bit positions of the compare flags inside alu_result.
    localparam int LT_BIT = 0;
    localparam int GE_BIT = 1;

    // Codes 6 and 7 are unused and behave like BR_NONE.
    function automatic logic is_branch(input logic [2:0] t);
        return (t >= 3'(BR_BEQ)) && (t <= 3'(BR_JMP));
    endfunction

    function automatic logic br_taken(input logic [2:0] t, input logic z,
                                      input logic lt, input logic ge);
        logic tk;
        tk = 1'b0;
        case (t)
            3'(BR_BEQ): tk = z;
            3'(BR_BNE): tk = !z;
            3'(BR_BLT): tk = lt;
            3'(BR_BGE): tk = ge;
            3'(BR_JMP): tk = 1'b1;
            default:    tk = 1'b0;
        endcase
        return tk;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear has priority over increment; increment stops at the maximum.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: redirect pulse, wrong-path flush and statistics.
//
//   state | meaning
//   IDLE  | accepting branches from EX
//   FLUSH | squashing wrong-path IF/ID and ID/EX for FLUSH_CYCLES unstalled cycles
module branch_resolve
    import branch_pkg::*;
#(
    parameter int N            = 20,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_ex,
    input  logic             stall,
    input  logic [2:0]       br_type,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_z,
    input  logic [N-1:0]     pc_ex,
    input  logic [N-1:0]     imm_ex,
    input  logic             clr_stats,
    output logic             redirect,
    output logic [N-1:0]     target_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_e     state;
    logic [2:0] flush_cnt;
    logic       accept;
    logic       taken;

    assign accept = valid_ex && !stall && (state == IDLE) && is_branch(br_type);
    assign taken  = br_taken(br_type, alu_z, alu_result[LT_BIT], alu_result[GE_BIT]);

    // Control FSM; all outputs registered so redirect and flushes rise together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= 3'd0;
            redirect    <= 1'b0;
            target_pc   <= '0;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
        end else begin
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && taken) begin
                        state       <= FLUSH;
                        flush_cnt   <= FLUSH_LOAD;
                        redirect    <= 1'b1;
                        target_pc   <= pc_ex + imm_ex;
                        flush_if_id <= 1'b1;
                        flush_id_ex <= 1'b1;
                    end
                end
                FLUSH: begin
                    // A stalled pipeline has not advanced, so the squash is stretched.
                    if (!stall) begin
                        if (flush_cnt == 3'd1) begin
                            state       <= IDLE;
                            flush_cnt   <= 3'd0;
                            flush_if_id <= 1'b0;
                            flush_id_ex <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    flush_cnt   <= 3'd0;
                    flush_if_id <= 1'b0;
                    flush_id_ex <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clr   (clr_stats),
        .count (br_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && taken),
        .clr   (clr_stats),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: redirect targets go through a queue.
module tb_branch_resolve;
    import branch_pkg::*;

    localparam int N     = 20;
    localparam int CNT_W = 16;
    localparam int MAXC  = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_ex;
    logic             stall;
    logic [2:0]       br_type;
    logic [N-1:0]     alu_result;
    logic             alu_z;
    logic [N-1:0]     pc_ex;
    logic [N-1:0]     imm_ex;
    logic             clr_stats;
    logic             redirect;
    logic [N-1:0]     target_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    int total = 0;
    int bad   = 0;
    int exp_br = 0;
    int exp_tk = 0;
    logic [N-1:0] exp_q[$];

    branch_resolve #(.N(N), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .stall(stall), .br_type(br_type),
        .alu_result(alu_result), .alu_z(alu_z), .pc_ex(pc_ex), .imm_ex(imm_ex),
        .clr_stats(clr_stats), .redirect(redirect), .target_pc(target_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (redirect === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_redirect: target_pc=%h with no branch pending", target_pc);
            end else begin
                logic [N-1:0] want;
                want = exp_q.pop_front();
                if (target_pc !== want) begin
                    bad++;
                    $display("FAIL redirect_target: got %h want %h", target_pc, want);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_ex = 1'b0; stall = 1'b0; br_type = 3'd0; alu_result = '0;
        alu_z = 1'b0; pc_ex = '0; imm_ex = '0; clr_stats = 1'b0;
    endtask

    task automatic model_accept(input logic tk);
        if (exp_br < MAXC) exp_br++;
        if (tk && exp_tk < MAXC) exp_tk++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        exp_br = 0; exp_tk = 0;
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        total++; if (target_pc !== '0) begin bad++; $display("FAIL reset_target: got %h want 0", target_pc); end
        total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b%b want 00", flush_if_id, flush_id_ex); end
        total++; if (br_count !== 16'd0 || taken_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", br_count, taken_count); end
    endtask

    task automatic test_beq_taken();
        valid_ex = 1'b1; br_type = BR_BEQ; alu_z = 1'b1; pc_ex = 20'h00100; imm_ex = 20'h00020;
        exp_q.push_back(20'h00120); model_accept(1'b1);
        step();
        clear_inputs();
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL beq_redirect: got %b want 1", redirect); end
        total++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin bad++; $display("FAIL beq_flush_c1: got %b%b want 11", flush_if_id, flush_id_ex); end
        step();
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL beq_pulse_width: got %b want 0", redirect); end
        total++; if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin bad++; $display("FAIL beq_flush_c2: got %b%b want 11", flush_if_id, flush_id_ex); end
        step();
        total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin bad++; $display("FAIL beq_flush_end: got %b%b want 00", flush_if_id, flush_id_ex); end
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL beq_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
    endtask

    task automatic test_blt_not_taken();
        valid_ex = 1'b1; br_type = BR_BLT; alu_result = 20'h00002; pc_ex = 20'h00400; imm_ex = 20'h00010;
        model_accept(1'b0);
        step();
        clear_inputs();
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL blt_redirect: got %b want 0", redirect); end
        total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin bad++; $display("FAIL blt_flush: got %b%b want 00", flush_if_id, flush_id_ex); end
        total++; if (target_pc !== 20'h00120) begin bad++; $display("FAIL blt_target_hold: got %h want 00120", target_pc); end
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL blt_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
    endtask

    task automatic test_none_codes();
        logic [2:0] codes [3];
        codes[0] = 3'd0; codes[1] = 3'd6; codes[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            valid_ex = 1'b1; br_type = codes[i]; alu_z = 1'b1; alu_result = 20'h00003;
            step();
        end
        clear_inputs();
        step();
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL none_codes_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
        total++; if (flush_if_id !== 1'b0) begin bad++; $display("FAIL none_codes_flush: got %b want 0", flush_if_id); end
    endtask

    task automatic test_jmp_wrap();
        valid_ex = 1'b1; br_type = BR_JMP; pc_ex = 20'hFFFF0; imm_ex = 20'h00020;
        exp_q.push_back(20'h00010); model_accept(1'b1);
        step();
        clear_inputs();
        total++; if (redirect !== 1'b1 || target_pc !== 20'h00010) begin bad++; $display("FAIL jmp_wrap: got %b/%h want 1/00010", redirect, target_pc); end
        step(); step();
    endtask

    task automatic test_stall_flush();
        int n = 0;
        int split = 0;
        valid_ex = 1'b1; br_type = BR_BGE; alu_result = 20'h00002; pc_ex = 20'h00200; imm_ex = 20'h00040;
        exp_q.push_back(20'h00240); model_accept(1'b1);
        step();
        for (int i = 0; i < 12; i++) begin
            if (flush_id_ex !== flush_if_id) split++;
            if (flush_if_id === 1'b1) begin
                n++;
                valid_ex = 1'b1; br_type = BR_BNE; alu_z = 1'b0; pc_ex = 20'h00500; imm_ex = 20'h00008;
                stall = (n <= 3);
            end else begin
                clear_inputs();
            end
            step();
        end
        clear_inputs();
        total++; if (n != 5) begin bad++; $display("FAIL stall_flush_len: got %0d want 5", n); end
        total++; if (split != 0) begin bad++; $display("FAIL stall_flush_pair: got %0d split cycles want 0", split); end
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL stall_flush_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
    endtask

    task automatic test_held_stall();
        valid_ex = 1'b1; br_type = BR_BEQ; alu_z = 1'b0; stall = 1'b1;
        step(); step();
        stall = 1'b0;
        model_accept(1'b0);
        step();
        clear_inputs();
        step();
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL held_stall_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
    endtask

    task automatic test_back_to_back();
        valid_ex = 1'b1; br_type = BR_JMP; pc_ex = 20'h00010; imm_ex = 20'h00100;
        exp_q.push_back(20'h00110); model_accept(1'b1);
        step();
        valid_ex = 1'b1; br_type = BR_BNE; alu_z = 1'b0; pc_ex = 20'h00300; imm_ex = 20'h00004;
        exp_q.push_back(20'h00304); model_accept(1'b1);
        step();
        total++; if (redirect !== 1'b0 || flush_if_id !== 1'b1) begin bad++; $display("FAIL b2b_flush_c2: got %b/%b want 0/1", redirect, flush_if_id); end
        step();
        total++; if (redirect !== 1'b0 || flush_if_id !== 1'b0) begin bad++; $display("FAIL b2b_exit_cycle: got %b/%b want 0/0", redirect, flush_if_id); end
        step();
        clear_inputs();
        total++; if (redirect !== 1'b1 || target_pc !== 20'h00304) begin bad++; $display("FAIL b2b_first_idle_accept: got %b/%h want 1/00304", redirect, target_pc); end
        step(); step(); step();
        total++; if (br_count !== 16'(exp_br) || taken_count !== 16'(exp_tk)) begin bad++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", br_count, taken_count, exp_br, exp_tk); end
    endtask

    task automatic test_reset_mid_flush();
        valid_ex = 1'b1; br_type = BR_BEQ; alu_z = 1'b1; pc_ex = 20'h00800; imm_ex = 20'h00010;
        exp_q.push_back(20'h00810); model_accept(1'b1);
        step();
        clear_inputs();
        rst = 1'b1;
        valid_ex = 1'b1; br_type = BR_JMP; pc_ex = 20'h00900;
        step();
        rst = 1'b0;
        clear_inputs();
        exp_br = 0; exp_tk = 0;
        total++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || redirect !== 1'b0) begin bad++; $display("FAIL rst_mid_flush: got %b%b%b want 000", flush_if_id, flush_id_ex, redirect); end
        total++; if (br_count !== 16'd0 || taken_count !== 16'd0) begin bad++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", br_count, taken_count); end
        step(); step(); step();
    endtask

    task automatic test_clr_stats();
        valid_ex = 1'b1; br_type = BR_JMP; clr_stats = 1'b1; pc_ex = 20'h00020; imm_ex = 20'h00020;
        exp_q.push_back(20'h00040);
        step();
        clear_inputs();
        exp_br = 0; exp_tk = 0;
        total++; if (br_count !== 16'd0 || taken_count !== 16'd0) begin bad++; $display("FAIL clr_stats: got %0d/%0d want 0/0", br_count, taken_count); end
        total++; if (flush_if_id !== 1'b1) begin bad++; $display("FAIL clr_stats_fsm: got %b want 1", flush_if_id); end
        step(); step();
    endtask

    task automatic test_saturation();
        valid_ex = 1'b1; br_type = BR_BLT; alu_result = '0;
        for (int i = 0; i < 65534; i++) begin
            model_accept(1'b0);
            step();
        end
        total++; if (br_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %h want fffe", br_count); end
        for (int i = 0; i < 3; i++) begin
            model_accept(1'b0);
            step();
        end
        total++; if (br_count !== 16'hFFFF || exp_br != MAXC) begin bad++; $display("FAIL sat_hold: got %h want ffff", br_count); end
        clr_stats = 1'b1;
        step();
        clear_inputs();
        total++; if (br_count !== 16'd0) begin bad++; $display("FAIL sat_clr_accept: got %h want 0", br_count); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_beq_taken();
        test_blt_not_taken();
        test_none_codes();
        test_jmp_wrap();
        test_stall_flush();
        test_held_stall();
        test_back_to_back();
        test_reset_mid_flush();
        test_clr_stats();
        test_saturation();
        step(); step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_redirects: got %0d unmatched want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
